mux_scan_ctrl: RTL and testbench

//   Upstream control stage for the 4:1 mux (mux4_1).
//   On start, steps the mux select through channels 0..3 and holds each for DWELL cycles.
//   At the end of each dwell, samples the mux output y into bit [sel] of a capture register.

---
 rtl/mux_scan_pkg.sv | 12 +
 rtl/mux_scan_ctrl.sv | 107 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants for the mux scan controller: channel count, select width
// and the FSM state encodings.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux select through every channel, samples y at the end of each
// dwell, and offers the 4-bit snapshot downstream over valid/ready.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              y,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    if (DWELL < 1) begin : g_bad_dwell
        $error("mux_scan_ctrl: DWELL must be at least 1");
    end

    // Handshake: a snapshot transfers on a rising edge where dout_valid and
    // dout_ready are both high; dout holds steady while valid waits for ready.

    logic [1:0]        r_state;
    logic [SEL_W-1:0]  r_sel;
    logic [CNT_W-1:0]  r_cnt;
    logic [NUM_CH-1:0] r_cap;
    logic [NUM_CH-1:0] r_dout;
    logic              r_valid;

    logic              w_last;
    logic              w_hs;
    logic [NUM_CH-1:0] w_snap;

    assign w_last = (r_cnt == CNT_W'(DWELL - 1));
    assign w_hs   = r_valid & dout_ready;

    // The final channel's bit goes straight from y into dout, bypassing r_cap.
    always_comb begin
        w_snap             = r_cap;
        w_snap[NUM_CH-1]   = y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_cap   <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SCAN;
                        r_sel   <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (w_last) begin
                        r_cnt        <= '0;
                        r_cap[r_sel] <= y;
                        if (r_sel == SEL_W'(NUM_CH - 1)) begin
                            r_dout  <= w_snap;
                            r_valid <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_sel <= r_sel + SEL_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        if (start) begin
                            r_state <= ST_SCAN;
                            r_sel   <= '0;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign sel        = r_sel;
    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign busy       = (r_state != ST_IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomised and directed bench for mux_scan_ctrl with a 4:1 mux modelled in
// place; a timing-based reference model feeds a scoreboard.
module tb_mux_scan_ctrl;

    localparam int DWELL = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main DUT (DWELL=2)
    logic       start = 1'b0;
    logic       dout_ready = 1'b0;
    logic [3:0] a = 4'b0000;
    logic       y;
    logic [1:0] sel;
    logic [3:0] dout;
    logic       dout_valid;
    logic       busy;
    logic [1:0] dbg_state;

    assign y = a[sel];

    mux_scan_ctrl #(.DWELL(DWELL)) u_dut (
        .clk(clk), .rst(rst), .start(start), .y(y), .sel(sel), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
        .dbg_state(dbg_state)
    );

    // second DUT (DWELL=1)
    logic       start2 = 1'b0;
    logic       dout_ready2 = 1'b1;
    logic [3:0] a2 = 4'b1111;
    logic       y2;
    logic [1:0] sel2;
    logic [3:0] dout2;
    logic       dout_valid2;
    logic       busy2;
    logic [1:0] dbg_state2;

    assign y2 = a2[sel2];

    mux_scan_ctrl #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start2), .y(y2), .sel(sel2), .dout(dout2),
        .dout_valid(dout_valid2), .dout_ready(dout_ready2), .busy(busy2),
        .dbg_state(dbg_state2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: phases and edge arithmetic from the scan rules
    localparam int P_IDLE = 0, P_SCAN = 1, P_DONE = 2;
    int         m_phase = P_IDLE;
    int         m_start = 0;
    int         cyc = 0;
    logic [1:0] m_sel = 2'd0;
    logic [3:0] m_snap = 4'b0000;
    logic [3:0] m_dout = 4'b0000;
    logic [3:0] exp_q[$];
    int         exp_t_q[$];

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = P_IDLE;
                m_sel   = 2'd0;
                m_dout  = 4'b0000;
                exp_q.delete();
                exp_t_q.delete();
            end else begin
                cyc++;
                case (m_phase)
                    P_IDLE: if (start) begin
                        m_phase = P_SCAN; m_start = cyc; m_sel = 2'd0;
                    end
                    P_SCAN: begin
                        int el, ch;
                        el = cyc - m_start;
                        if (el % DWELL == 0) begin
                            ch = el / DWELL - 1;
                            m_snap[ch] = a[ch];
                            if (ch == 3) begin
                                m_dout  = m_snap;
                                m_phase = P_DONE;
                                exp_q.push_back(m_snap);
                                exp_t_q.push_back(m_start + 4 * DWELL);
                            end else begin
                                m_sel = 2'(ch + 1);
                            end
                        end
                    end
                    default: if (dout_ready) begin
                        if (start) begin
                            m_phase = P_SCAN; m_start = cyc; m_sel = 2'd0;
                        end else begin
                            m_phase = P_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // monitor: compare every cycle, pop the scoreboard when a snapshot appears
    logic prev_valid = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
                chk("sel", 32'(sel), 32'(m_sel));
                chk("dout_valid", 32'(dout_valid), 32'(m_phase == P_DONE));
                chk("dout_hold", 32'(dout), 32'(m_dout));
                if (dout_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_snapshot", 32'(1), 32'(0));
                    end else begin
                        chk("snapshot", 32'(dout), 32'(exp_q.pop_front()));
                        chk("latency_edge", 32'(cyc), 32'(exp_t_q.pop_front()));
                    end
                end
                prev_valid = dout_valid;
            end
        end
    end

    // driver tasks
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc);
        int k;
        k = 0;
        while (!dout_valid && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (!dout_valid) chk("wait_valid_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        // reset state, both instances
        #1;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_busy2", 32'(busy2), 32'd0);
        chk("rst_valid2", 32'(dout_valid2), 32'd0);
        @(negedge clk) rst = 1'b0;
        cycles(2);

        // static data scan
        a = 4'b1010; dout_ready = 1'b1;
        pulse_start();
        cycles(12);

        // backpressure with ignored start pulses
        a = 4'b0110; dout_ready = 1'b0;
        pulse_start();
        cycles(4);
        pulse_start();
        cycles(8);
        pulse_start();
        cycles(6);
        chk("bp_valid_held", 32'(dout_valid), 32'd1);
        chk("bp_dout", 32'(dout), 32'(4'b0110));
        dout_ready = 1'b1;
        cycles(3);

        // back-to-back scans with start held
        a = 4'b0001;
        @(negedge clk) start = 1'b1;
        cycles(1);
        wait_valid(20);
        a = 4'b1000;
        cycles(1);
        wait_valid(20);
        chk("b2b_second", 32'(dout), 32'(4'b1000));
        start = 1'b0;
        cycles(3);

        // channel 1 glitches only in its first dwell cycle
        a = 4'b1101;
        pulse_start();
        cycles(2);
        a = 4'b1111;
        cycles(1);
        a = 4'b1101;
        cycles(8);
        chk("settle_dout", 32'(dout), 32'(4'b1101));

        // reset mid-scan while sel==2
        a = 4'b1011;
        pulse_start();
        cycles(4);
        chk("pre_rst_sel", 32'(sel), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_sel", 32'(sel), 32'd0);
        chk("async_dout", 32'(dout), 32'd0);
        chk("async_valid", 32'(dout_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        @(negedge clk) rst = 1'b0;
        a = 4'b0101;
        pulse_start();
        cycles(12);

        // DWELL=1 instance: valid exactly 4 edges after the start edge
        begin
            int k;
            @(negedge clk) start2 = 1'b1;
            @(posedge clk);
            #1 start2 = 1'b0;
            k = 0;
            while (k < 20) begin
                @(posedge clk);
                k++;
                #1;
                if (dout_valid2) break;
            end
            chk("dwell1_latency", 32'(k), 32'd4);
            chk("dwell1_dout", 32'(dout2), 32'(4'b1111));
            cycles(3);
            chk("dwell1_idle", 32'(busy2), 32'd0);
        end

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a          = 4'($urandom_range(0, 15));
            start      = ($urandom_range(0, 3) == 0);
            dout_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk) start = 1'b0; dout_ready = 1'b1;
        cycles(20);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
